// File: rtl/spi_boot_loader_if.sv
// AHB-Lite bus bundle between the boot loader (master) and the SPI flash slave.
interface spi_boot_loader_if;
   logic [31:0] M_HADDR;
   logic [1:0]  M_HTRANS;
   logic        M_HWRITE;
   logic [2:0]  M_HSIZE;
   logic [2:0]  M_HBURST;
   logic [31:0] M_HWDATA;
   logic [31:0] M_HRDATA;
   logic        M_HREADY;
   logic [1:0]  M_HRESP;

   modport master (
      output M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HWDATA,
      input  M_HRDATA, M_HREADY, M_HRESP
   );

   modport slave (
      input  M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HWDATA,
      output M_HRDATA, M_HREADY, M_HRESP
   );
endinterface

// File: rtl/spi_boot_loader.sv
// Non-pipelined AHB-Lite boot master: programs the flash control register, copies WORD_CNT words
// flash->SRAM and holds CPU_RST until done. `define BOOT_CHECKSUM_EN adds a trailer-word checksum check.
module spi_boot_loader #(
   parameter logic [31:0] CTRL_REG_ADDR = 32'h0800_000C,
   parameter logic [31:0] CTRL_WORD     = 32'h0003_0001,
   parameter logic [31:0] SRC_ADDR      = 32'h0000_0000,
   parameter logic [31:0] DST_ADDR      = 32'h2000_0000,
   parameter logic [15:0] WORD_CNT      = 16'd1024
) (
   input  logic              HCLK,
   input  logic              HRST,
   input  logic              START,
   input  logic              SPI_INIT,
   spi_boot_loader_if.master bus,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic              CPU_RST
`ifdef BOOT_CHECKSUM_EN
   ,
   output logic [31:0]       CHKSUM
`endif
);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_INIT, S_CFG_A, S_CFG_D, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_DONE, S_ERROR
`ifdef BOOT_CHECKSUM_EN
      , S_CK_A, S_CK_D
`endif
   } state_t;

   state_t      state, state_nx;
   logic [31:0] haddr, haddr_nx, hwdata, hwdata_nx, hold, hold_nx;
   logic [1:0]  htrans, htrans_nx;
   logic        hwrite, hwrite_nx;
   logic [15:0] cnt, cnt_nx, cnt_inc;
   logic        busy_nx, done_nx, err_nx, cpu_rst_nx;
   logic        go_err, go_end, bus_ok;
`ifdef BOOT_CHECKSUM_EN
   logic [31:0] sum, sum_nx;
   assign CHKSUM = sum;
`endif

   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

   assign bus_ok       = (bus.M_HRESP == 2'b00);
   assign cnt_inc      = cnt + 16'd1;
   assign bus.M_HADDR  = haddr;
   assign bus.M_HTRANS = htrans;
   assign bus.M_HWRITE = hwrite;
   assign bus.M_HWDATA = hwdata;
   assign bus.M_HSIZE  = 3'b010;
   assign bus.M_HBURST = 3'b000;

   // htrans defaults to IDLE, so NONSEQ lasts exactly until the address phase is accepted
   always_comb begin
      state_nx   = state;
      haddr_nx   = haddr;
      htrans_nx  = HTRANS_IDLE;
      hwrite_nx  = hwrite;
      hwdata_nx  = hwdata;
      hold_nx    = hold;
      cnt_nx     = cnt;
      busy_nx    = BUSY;
      done_nx    = DONE;
      err_nx     = ERR;
      cpu_rst_nx = CPU_RST;
      go_err     = 1'b0;
      go_end     = 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_nx     = sum;
`endif
      case (state)
         S_IDLE, S_DONE, S_ERROR: if (START) begin
            state_nx   = S_WAIT_INIT;
            busy_nx    = 1'b1;
            done_nx    = 1'b0;
            err_nx     = 1'b0;
            cpu_rst_nx = 1'b1;
            cnt_nx     = 16'd0;
`ifdef BOOT_CHECKSUM_EN
            sum_nx     = 32'd0;
`endif
         end
         S_WAIT_INIT: if (SPI_INIT) begin
            state_nx  = S_CFG_A;
            haddr_nx  = CTRL_REG_ADDR;
            hwrite_nx = 1'b1;
            htrans_nx = HTRANS_NONSEQ;
         end
         S_CFG_A: if (bus.M_HREADY) begin
            state_nx  = S_CFG_D;
            hwdata_nx = CTRL_WORD;
         end else htrans_nx = HTRANS_NONSEQ;
         S_CFG_D: if (bus.M_HREADY) begin
            if (!bus_ok) go_err = 1'b1;
            else if (WORD_CNT == 16'd0) go_end = 1'b1;
            else begin
               state_nx  = S_RD_A;
               haddr_nx  = word_addr(SRC_ADDR, cnt);
               hwrite_nx = 1'b0;
               htrans_nx = HTRANS_NONSEQ;
            end
         end
         S_RD_A: if (bus.M_HREADY) state_nx = S_RD_D;
                 else htrans_nx = HTRANS_NONSEQ;
         S_RD_D: if (bus.M_HREADY) begin
            if (!bus_ok) go_err = 1'b1;
            else begin
               hold_nx   = bus.M_HRDATA;
               state_nx  = S_WR_A;
               haddr_nx  = word_addr(DST_ADDR, cnt);
               hwrite_nx = 1'b1;
               htrans_nx = HTRANS_NONSEQ;
            end
         end
         S_WR_A: if (bus.M_HREADY) begin
            state_nx  = S_WR_D;
            hwdata_nx = hold;
         end else htrans_nx = HTRANS_NONSEQ;
         S_WR_D: if (bus.M_HREADY) begin
            if (!bus_ok) go_err = 1'b1;
            else begin
               cnt_nx = cnt_inc;
`ifdef BOOT_CHECKSUM_EN
               sum_nx = sum + hold;
`endif
               if (cnt_inc == WORD_CNT) go_end = 1'b1;
               else begin
                  state_nx  = S_RD_A;
                  haddr_nx  = word_addr(SRC_ADDR, cnt_inc);
                  hwrite_nx = 1'b0;
                  htrans_nx = HTRANS_NONSEQ;
               end
            end
         end
`ifdef BOOT_CHECKSUM_EN
         S_CK_A: if (bus.M_HREADY) state_nx = S_CK_D;
                 else htrans_nx = HTRANS_NONSEQ;
         S_CK_D: if (bus.M_HREADY) begin
            if (!bus_ok || bus.M_HRDATA != sum) go_err = 1'b1;
            else begin
               state_nx   = S_DONE;
               busy_nx    = 1'b0;
               done_nx    = 1'b1;
               cpu_rst_nx = 1'b0;
            end
         end
`endif
         default: state_nx = S_IDLE;
      endcase

      if (go_end) begin
`ifdef BOOT_CHECKSUM_EN
         // trailer word sits right after the image
         state_nx   = S_CK_A;
         haddr_nx   = word_addr(SRC_ADDR, WORD_CNT);
         hwrite_nx  = 1'b0;
         htrans_nx  = HTRANS_NONSEQ;
`else
         state_nx   = S_DONE;
         busy_nx    = 1'b0;
         done_nx    = 1'b1;
         cpu_rst_nx = 1'b0;
`endif
      end
      if (go_err) begin
         state_nx = S_ERROR;
         busy_nx  = 1'b0;
         err_nx   = 1'b1;
      end
   end

   always_ff @(posedge HCLK or posedge HRST) begin
      if (HRST) begin
         state   <= S_IDLE;
         haddr   <= 32'd0;
         htrans  <= HTRANS_IDLE;
         hwrite  <= 1'b0;
         hwdata  <= 32'd0;
         hold    <= 32'd0;
         cnt     <= 16'd0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
         CPU_RST <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
         sum     <= 32'd0;
`endif
      end else begin
         state   <= state_nx;
         haddr   <= haddr_nx;
         htrans  <= htrans_nx;
         hwrite  <= hwrite_nx;
         hwdata  <= hwdata_nx;
         hold    <= hold_nx;
         cnt     <= cnt_nx;
         BUSY    <= busy_nx;
         DONE    <= done_nx;
         ERR     <= err_nx;
         CPU_RST <= cpu_rst_nx;
`ifdef BOOT_CHECKSUM_EN
         sum     <= sum_nx;
`endif
      end
   end
endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: AHB slave model with wait states / error injection, expected
// transaction list built from the boot rules, plus reset, zero-length and checksum sequences.
`timescale 1ns/1ps
module tb_spi_boot_loader;
   localparam logic [31:0] CTRL_A = 32'h0800_000C;
   localparam logic [31:0] CTRL_W = 32'h0003_0001;
   localparam logic [31:0] SRC    = 32'h0000_0000;
   localparam logic [31:0] DST    = 32'h2000_0000;
   localparam int          NW     = 4;

   logic HCLK = 1'b0, HRST = 1'b1, START = 1'b0, START0 = 1'b0, SPI_INIT = 1'b0;
   logic BUSY, DONE, ERR, CPU_RST, BUSY0, DONE0, ERR0, CPU_RST0;
`ifdef BOOT_CHECKSUM_EN
   logic [31:0] CHKSUM, CHKSUM0;
`endif

   spi_boot_loader_if bus();
   spi_boot_loader_if bus0();

   always #5 HCLK = ~HCLK;

   spi_boot_loader #(.CTRL_REG_ADDR(CTRL_A), .CTRL_WORD(CTRL_W), .SRC_ADDR(SRC), .DST_ADDR(DST),
                     .WORD_CNT(16'd4)) dut (
      .HCLK(HCLK), .HRST(HRST), .START(START), .SPI_INIT(SPI_INIT), .bus(bus),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CPU_RST(CPU_RST)
`ifdef BOOT_CHECKSUM_EN
      , .CHKSUM(CHKSUM)
`endif
   );

   spi_boot_loader #(.CTRL_REG_ADDR(CTRL_A), .CTRL_WORD(CTRL_W), .SRC_ADDR(SRC), .DST_ADDR(DST),
                     .WORD_CNT(16'd0)) dut0 (
      .HCLK(HCLK), .HRST(HRST), .START(START0), .SPI_INIT(SPI_INIT), .bus(bus0),
      .BUSY(BUSY0), .DONE(DONE0), .ERR(ERR0), .CPU_RST(CPU_RST0)
`ifdef BOOT_CHECKSUM_EN
      , .CHKSUM(CHKSUM0)
`endif
   );

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      int rd_wait;   // -1: random 0..5 per read
      int err_read;  // 1-based read index answered with ERROR, 0 = none
      int init_dly;
      bit do_reset;
      bit exp_done;
      int exp_wr;
   } vec_t;

   int   n_chk = 0, n_fail = 0;
   logic [31:0] flash [0:7];
   logic [31:0] sram  [0:7];
   int   rd_wait = 0, err_read = 0, rd_num = 0, nonseq_cnt = 0, data_wr = 0, stab_bad = 0;
   bit   dp_act = 0, dp_wr = 0;
   logic [31:0] dp_addr = 0;
   int   wait_left = 0;
   txn_t log_q[$];
   txn_t exp_q[$];

   int   n0 = 0;
   bit   pend0 = 0;
   txn_t first0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // AHB slave for the main DUT: flash below 0x2000_0000, SRAM at 0x2000_0000
   initial begin
      bus.M_HREADY = 1'b1; bus.M_HRESP = 2'b00; bus.M_HRDATA = 32'd0;
      forever begin
         @(negedge HCLK);
         if (HRST) begin
            dp_act = 0; bus.M_HREADY = 1'b1; bus.M_HRESP = 2'b00;
         end else if (dp_act) begin
            if (bus.M_HTRANS != 2'b00 || bus.M_HADDR != dp_addr) stab_bad++;
            if (wait_left > 0) begin
               wait_left--;
               bus.M_HREADY = 1'b0; bus.M_HRESP = 2'b00; bus.M_HRDATA = $urandom;
            end else begin
               bus.M_HREADY = 1'b1; dp_act = 0;
               if (dp_wr) begin
                  bus.M_HRESP = 2'b00;
                  log_q.push_back({1'b1, dp_addr, bus.M_HWDATA});
                  if (dp_addr[31:29] == 3'b001) begin
                     sram[dp_addr[4:2]] = bus.M_HWDATA;
                     data_wr++;
                  end
               end else begin
                  rd_num++;
                  if (rd_num == err_read) begin
                     bus.M_HRESP = 2'b01; bus.M_HRDATA = 32'hDEAD_BEEF;
                  end else begin
                     bus.M_HRESP = 2'b00; bus.M_HRDATA = flash[dp_addr[4:2]];
                  end
                  log_q.push_back({1'b0, dp_addr, bus.M_HRDATA});
               end
            end
         end else begin
            bus.M_HREADY = 1'b1; bus.M_HRESP = 2'b00;
            if (bus.M_HTRANS == 2'b10) begin
               nonseq_cnt++;
               dp_act = 1; dp_wr = bus.M_HWRITE; dp_addr = bus.M_HADDR;
               wait_left = dp_wr ? 0 : (rd_wait < 0 ? int'($urandom_range(0, 5)) : rd_wait);
            end
         end
      end
   end

   // zero-wait OKAY slave for the zero-length instance; records its first transfer
   initial begin
      bus0.M_HREADY = 1'b1; bus0.M_HRESP = 2'b00; bus0.M_HRDATA = 32'd0;
      forever begin
         @(negedge HCLK);
         if (HRST) begin
            n0 = 0; pend0 = 0;
         end else if (pend0) begin
            if (n0 == 1) first0.data = bus0.M_HWDATA;
            pend0 = 0;
         end else if (bus0.M_HTRANS == 2'b10) begin
            n0++; pend0 = 1;
            if (n0 == 1) begin first0.wr = bus0.M_HWRITE; first0.addr = bus0.M_HADDR; end
         end
      end
   end

   // Expected traffic: config write, then read/write pairs until done or the failing read
   task automatic build_exp(input int err_rd);
      exp_q.delete();
      exp_q.push_back({1'b1, CTRL_A, CTRL_W});
      for (int i = 0; i < NW; i++) begin
         if (err_rd == i + 1) begin
            exp_q.push_back({1'b0, SRC + 32'(4 * i), 32'hDEAD_BEEF});
            return;
         end
         exp_q.push_back({1'b0, SRC + 32'(4 * i), flash[i]});
         exp_q.push_back({1'b1, DST + 32'(4 * i), flash[i]});
      end
`ifdef BOOT_CHECKSUM_EN
      exp_q.push_back({1'b0, SRC + 32'(4 * NW), flash[NW]});
`endif
   endtask

   task automatic do_reset();
      HRST = 1'b1; START = 1'b0; START0 = 1'b0; SPI_INIT = 1'b0;
      repeat (2) @(posedge HCLK);
      #1 HRST = 1'b0;
   endtask

   task automatic go(input vec_t v);
      int n;
      rd_wait = v.rd_wait; err_read = v.err_read;
      rd_num = 0; nonseq_cnt = 0; data_wr = 0; stab_bad = 0;
      log_q.delete();
      for (int i = 0; i < 8; i++) sram[i] = 32'd0;
      SPI_INIT = 1'b0;
      @(posedge HCLK); #1 START = 1'b1;
      @(posedge HCLK); #1 START = 1'b0;
      chk("busy_after_start", 32'(BUSY), 32'd1);
      chk("done_cleared", 32'(DONE), 32'd0);
      chk("err_cleared", 32'(ERR), 32'd0);
      chk("cpu_rst_held", 32'(CPU_RST), 32'd1);
      repeat (v.init_dly) @(posedge HCLK);
      chk("no_xfer_before_init", 32'(nonseq_cnt), 32'd0);
      #1 SPI_INIT = 1'b1;
      for (int c = 0; c < 20000 && !(DONE || ERR); c++) @(negedge HCLK);
      chk("finish_in_budget", 32'(DONE || ERR), 32'd1);
      chk("done_flag", 32'(DONE), 32'(v.exp_done));
      chk("err_flag", 32'(ERR), 32'(!v.exp_done));
      chk("cpu_rst_final", 32'(CPU_RST), 32'(!v.exp_done));
      chk("busy_final", 32'(BUSY), 32'd0);
      chk("sram_writes", 32'(data_wr), 32'(v.exp_wr));
      chk("wait_stability", 32'(stab_bad), 32'd0);
      for (int i = 0; i < v.exp_wr; i++) chk("sram_word", sram[i], flash[i]);
      build_exp(v.err_read);
      chk("txn_count", 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk("txn_dir", 32'(log_q[i].wr), 32'(exp_q[i].wr));
         chk("txn_addr", log_q[i].addr, exp_q[i].addr);
         chk("txn_data", log_q[i].data, exp_q[i].data);
      end
      n = nonseq_cnt;
      repeat (20) @(negedge HCLK);
      chk("quiet_after_end", 32'(nonseq_cnt), 32'(n));
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] s;
      if (v.do_reset) do_reset();
      s = 32'd0;
      for (int i = 0; i < 8; i++) flash[i] = $urandom;
      for (int i = 0; i < NW; i++) s = s + flash[i];
      flash[NW] = s;
      go(v);
   endtask

   vec_t tbl [6];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //          rd_wait err init rst done wr
      tbl[0] = '{0,      0,  10,  1,  1,   4};
      tbl[1] = '{200,    0,  3,   0,  1,   4};
      tbl[2] = '{0,      3,  10,  0,  0,   2};
      tbl[3] = '{-1,     0,  0,   0,  1,   4};
      tbl[4] = '{2,      1,  5,   1,  0,   0};
      tbl[5] = '{-1,     4,  1,   0,  0,   3};

      do_reset();
      chk("rst_htrans", 32'(bus.M_HTRANS), 32'd0);
      chk("rst_haddr", bus.M_HADDR, 32'd0);
      chk("rst_hwrite", 32'(bus.M_HWRITE), 32'd0);
      chk("rst_hwdata", bus.M_HWDATA, 32'd0);
      chk("rst_hsize", 32'(bus.M_HSIZE), 32'd2);
      chk("rst_hburst", 32'(bus.M_HBURST), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_cpu_rst", 32'(CPU_RST), 32'd1);

      foreach (tbl[k]) run_vec(tbl[k]);

      // asynchronous reset in the middle of a stalled read data phase
      do_reset();
      rd_wait = 200; err_read = 0; rd_num = 0;
      @(posedge HCLK); #1 START = 1'b1;
      @(posedge HCLK); #1 START = 1'b0; SPI_INIT = 1'b1;
      for (int c = 0; c < 2000 && !(dp_act && !dp_wr); c++) @(negedge HCLK);
      repeat (3) @(negedge HCLK);
      chk("in_read_wait", 32'(bus.M_HREADY), 32'd0);
      #2 HRST = 1'b1;
      #1;
      chk("arst_htrans", 32'(bus.M_HTRANS), 32'd0);
      chk("arst_haddr", bus.M_HADDR, 32'd0);
      chk("arst_busy", 32'(BUSY), 32'd0);
      chk("arst_cpu_rst", 32'(CPU_RST), 32'd1);
      chk("arst_done", 32'(DONE), 32'd0);

      // zero-length image on the second instance
      do_reset();
      SPI_INIT = 1'b1;
      @(posedge HCLK); #1 START0 = 1'b1;
      @(posedge HCLK); #1 START0 = 1'b0;
      for (int c = 0; c < 200 && !(DONE0 || ERR0); c++) @(negedge HCLK);
      repeat (5) @(negedge HCLK);
`ifdef BOOT_CHECKSUM_EN
      chk("zero_len_xfers", 32'(n0), 32'd2);
`else
      chk("zero_len_xfers", 32'(n0), 32'd1);
`endif
      chk("zero_len_dir", 32'(first0.wr), 32'd1);
      chk("zero_len_addr", first0.addr, CTRL_A);
      chk("zero_len_data", first0.data, CTRL_W);
      chk("zero_len_done", 32'(DONE0), 32'd1);
      chk("zero_len_cpu_rst", 32'(CPU_RST0), 32'd0);
      chk("zero_len_err", 32'(ERR0), 32'd0);

`ifdef BOOT_CHECKSUM_EN
      // image 1,2,3,4 with matching and then mismatching trailer
      do_reset();
      for (int i = 0; i < NW; i++) flash[i] = 32'(i + 1);
      flash[NW] = 32'd10;
      go('{0, 0, 2, 0, 1, 4});
      chk("chksum_ok_sum", CHKSUM, 32'd10);
      flash[NW] = 32'd11;
      go('{0, 0, 2, 0, 0, 4});
      chk("chksum_bad_sum", CHKSUM, 32'd10);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
